// File: rtl/jtkunio_pkg.sv
// jtkunio_pkg: shared constants for the Kunio colour mixer
package jtkunio_pkg;
  localparam logic [1:0] CHAR_PFX = 2'b00;
  localparam logic [1:0] SCR_PFX  = 2'b01;
  localparam logic       OBJ_PFX  = 1'b1;
  localparam int GFX_CHAR = 0;
  localparam int GFX_SCR  = 1;
  localparam int GFX_OBJ  = 2;
  localparam int PIPE_LAT = 3;
  typedef logic [7:0] pal_idx_t;
endpackage

// File: rtl/jtkunio_colmix_prio.sv
// jtkunio_colmix_prio: combinational layer priority and palette index select
module jtkunio_colmix_prio import jtkunio_pkg::*; (
  input  logic [4:0] char_code,
  input  logic [6:0] obj_pxl,
  input  logic [5:0] scr_pxl,
  input  logic [2:0] gfx_en,
  input  logic       scr_force,
  output pal_idx_t   idx,
  output logic       black
);
  logic char_op, obj_op, scr_op;
  always_comb begin
    char_op = gfx_en[GFX_CHAR] && char_code[1:0] != 2'd0;
    obj_op  = gfx_en[GFX_OBJ] && obj_pxl[2:0] != 3'd0;
    scr_op  = gfx_en[GFX_SCR];
    black   = !scr_force && !char_op && !obj_op && !scr_op;
    idx = scr_force ? {SCR_PFX, scr_pxl} :
          char_op   ? {1'b0, CHAR_PFX, char_code} :
          obj_op    ? {OBJ_PFX, obj_pxl} :
          scr_op    ? {SCR_PFX, scr_pxl} : '0;
  end
endmodule

// File: rtl/jtkunio_colmix.sv
// jtkunio_colmix: layer priority, palette lookup and blanking for the final RGB output
module jtkunio_colmix import jtkunio_pkg::*; #(
  parameter SIMFILE_LO = "pal_lo.bin",
  parameter SIMFILE_HI = "pal_hi.bin"
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
  input  logic       lhbl,
  input  logic       lvbl,
  input  logic [5:0] char_pxl,
  input  logic [6:0] obj_pxl,
  input  logic [5:0] scr_pxl,
  input  logic [3:0] gfx_en,
  input  logic [8:0] cpu_addr,
  input  logic       pal_cs,
  input  logic       cpu_wrn,
  input  logic [7:0] cpu_dout,
  output logic [7:0] cpu_din,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       lhbl_dly,
  output logic       lvbl_dly,
  input  logic [7:0] debug_bus
);
  // words are {B,G,R}; the high byte's upper nibble is never stored and reads back as 0
  logic [11:0] ram [256];
  logic [11:0] q, pal2;
  logic [1:0] we;
  pal_idx_t idx, idx1;
  logic black, blk1, blk2;
  logic [PIPE_LAT-1:0] hs, vs;
  logic unused_in;
  assign unused_in = ^{char_pxl[2], gfx_en[3], debug_bus[6:0], SIMFILE_LO == SIMFILE_HI};
  assign we = {cpu_addr[8], ~cpu_addr[8]} & {2{pal_cs & ~cpu_wrn}};
  assign lhbl_dly = hs[PIPE_LAT-1];
  assign lvbl_dly = vs[PIPE_LAT-1];
  jtkunio_colmix_prio u_prio (
    .char_code({char_pxl[5:3], char_pxl[1:0]}),
    .obj_pxl(obj_pxl),
    .scr_pxl(scr_pxl),
    .gfx_en(gfx_en[2:0]),
    .scr_force(debug_bus[7]),
    .idx(idx),
    .black(black)
  );
  // scan read sees pre-write data on a same-index collision
  always_ff @(posedge clk) begin
    if (we[0]) ram[cpu_addr[7:0]][7:0] <= cpu_dout;
    if (we[1]) ram[cpu_addr[7:0]][11:8] <= cpu_dout[3:0];
    q <= ram[idx1];
  end
  always_ff @(posedge clk)
    if (rst) cpu_din <= '0;
    else cpu_din <= cpu_addr[8] ? {4'h0, ram[cpu_addr[7:0]][11:8]} : ram[cpu_addr[7:0]][7:0];
  always_ff @(posedge clk)
    if (rst) begin
      idx1 <= '0;
      blk1 <= 1'b0;
      pal2 <= '0;
      blk2 <= 1'b0;
      hs <= '0;
      vs <= '0;
      {blue, green, red} <= '0;
    end else if (pxl_cen) begin
      idx1 <= idx;
      blk1 <= black;
      pal2 <= q;
      blk2 <= blk1;
      hs <= {hs[PIPE_LAT-2:0], lhbl};
      vs <= {vs[PIPE_LAT-2:0], lvbl};
      {blue, green, red} <= (blk2 || !(hs[1] && vs[1])) ? '0 : pal2;
    end
endmodule
